apb_snn_csr: RTL and testbench

APB completer (slave) that terminates the testbench/host APB bus and holds the SNN core's control/status registers and synaptic weight table. It answers the psel/penable/pwrite/paddr/pwdata transfers issued by the APB driver, returning prdata and pready with a programmable number of wait states. It drives static configuration into the SNN core and samples its status.

---
 rtl/apb_snn_csr_if.sv | 22 ++
 rtl/apb_snn_csr.sv | 137 +++++++++++++
 tb/tb_apb_snn_csr.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_snn_csr_if.sv
// APB bus bundle between the host-side driver and the SNN CSR block.
// A transfer is a setup cycle (psel=1, penable=0) followed by access cycles (psel=1,
// penable=1); it completes on the edge where psel & penable & pready are all high.
interface apb_snn_csr_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/apb_snn_csr.sv
// APB completer holding the SNN core control/status registers and weight table,
// answering each transfer after WAIT_CYCLES programmable wait states.
module apb_snn_csr #(
  parameter int NUM_WEIGHTS = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  apb_snn_csr_if.slave             bus,
  output logic                     snn_enable,
  output logic                     soft_clear,
  output logic [15:0]              threshold,
  output logic [7:0]               leak,
  output logic [NUM_WEIGHTS*8-1:0] weights,
  input  logic                     busy_i,
  input  logic [15:0]              spike_count_i,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [2:0] CNT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  state_t      state;
  logic [2:0]  cnt;
  logic [13:0] addr_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [31:0] scratch_q;
  logic [7:0]  weight_q [NUM_WEIGHTS];

  assign dbg_state = state;

  for (genvar g = 0; g < NUM_WEIGHTS; g++) begin : g_pack
    assign weights[8*g +: 8] = weight_q[g];
  end

  // Word-indexed read decode; weights start at word 64 (byte 0x0100).
  function automatic logic [31:0] read_mux(input logic [13:0] w);
    logic [31:0] v;
    v = '0;
    case (w)
      14'd0:   v = {31'b0, snn_enable};
      14'd1:   v = {spike_count_i, 15'b0, busy_i};
      14'd2:   v = {16'b0, threshold};
      14'd3:   v = {24'b0, leak};
      14'd4:   v = scratch_q;
      default: begin
        for (int i = 0; i < NUM_WEIGHTS; i++) begin
          if (w == 14'(64 + i)) v = {24'b0, weight_q[i]};
        end
      end
    endcase
    return v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      bus.prdata  <= '0;
      bus.pready  <= 1'b0;
      snn_enable  <= 1'b0;
      soft_clear  <= 1'b0;
      threshold   <= 16'h0100;
      leak        <= 8'h01;
      scratch_q   <= '0;
      for (int i = 0; i < NUM_WEIGHTS; i++) weight_q[i] <= '0;
    end else begin
      soft_clear <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.psel && !bus.penable) begin
            addr_q  <= bus.paddr[15:2];
            write_q <= bus.pwrite;
            wdata_q <= bus.pwdata;
            if (WAIT_CYCLES == 0) begin
              state      <= S_ACK;
              bus.pready <= 1'b1;
              bus.prdata <= bus.pwrite ? 32'h0 : read_mux(bus.paddr[15:2]);
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (!bus.psel) begin
            state <= S_IDLE;
          end else if (cnt == 3'd0) begin
            state      <= S_ACK;
            bus.pready <= 1'b1;
            bus.prdata <= write_q ? 32'h0 : read_mux(addr_q);
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_ACK: begin
          if (!bus.psel) begin
            state      <= S_IDLE;
            bus.pready <= 1'b0;
            bus.prdata <= '0;
          end else if (bus.penable) begin
            // Completion edge: the write commits here and only here.
            if (write_q) begin
              case (addr_q)
                14'd0: begin
                  snn_enable <= wdata_q[0];
                  soft_clear <= wdata_q[1];
                end
                14'd2:   threshold <= wdata_q[15:0];
                14'd3:   leak      <= wdata_q[7:0];
                14'd4:   scratch_q <= wdata_q;
                default: ;
              endcase
              for (int i = 0; i < NUM_WEIGHTS; i++) begin
                if (addr_q == 14'(64 + i)) weight_q[i] <= wdata_q[7:0];
              end
            end
            state      <= S_IDLE;
            bus.pready <= 1'b0;
            bus.prdata <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_snn_csr.sv
// Directed bench for apb_snn_csr: a register-map model checked every cycle against
// the main instance (WAIT_CYCLES=1), plus a zero-wait instance for back-to-back timing.
module tb_apb_snn_csr;
  localparam int NW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared driver signals, steered to one instance by target (0 = main, 1 = zero-wait)
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, target = 1'b0;
  logic [15:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic        busy_i = 1'b0;
  logic [15:0] spike_count_i = '0;

  apb_snn_csr_if b1 ();
  apb_snn_csr_if b0 ();

  assign b1.psel = psel & ~target;
  assign b0.psel = psel & target;
  assign b1.penable = penable;
  assign b0.penable = penable;
  assign b1.pwrite = pwrite;
  assign b0.pwrite = pwrite;
  assign b1.paddr = paddr;
  assign b0.paddr = paddr;
  assign b1.pwdata = pwdata;
  assign b0.pwdata = pwdata;

  logic              en1, sc1, en0, sc0;
  logic [15:0]       thr1, thr0;
  logic [7:0]        lk1, lk0;
  logic [NW*8-1:0]   w1, w0;
  logic [1:0]        st1, st0;

  apb_snn_csr #(.NUM_WEIGHTS(NW), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .bus(b1), .snn_enable(en1), .soft_clear(sc1),
    .threshold(thr1), .leak(lk1), .weights(w1), .busy_i(busy_i),
    .spike_count_i(spike_count_i), .dbg_state(st1)
  );

  apb_snn_csr #(.NUM_WEIGHTS(NW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0), .snn_enable(en0), .soft_clear(sc0),
    .threshold(thr0), .leak(lk0), .weights(w0), .busy_i(busy_i),
    .spike_count_i(spike_count_i), .dbg_state(st0)
  );

  wire        pready_m = target ? b0.pready : b1.pready;
  wire [31:0] prdata_m = target ? b0.prdata : b1.prdata;

  // ---------------- model of the main instance ----------------
  logic        m_en;
  logic [15:0] m_thr;
  logic [7:0]  m_leak;
  logic [31:0] m_scratch;
  logic [7:0]  m_w [NW];
  int          m_sc_cyc;

  task automatic model_reset();
    m_en = 1'b0; m_thr = 16'h0100; m_leak = 8'h01; m_scratch = '0;
    for (int i = 0; i < NW; i++) m_w[i] = '0;
    m_sc_cyc = -1;
  endtask

  function automatic logic [31:0] m_read(input logic [15:0] a);
    logic [15:0] b;
    b = {a[15:2], 2'b00};
    if (b == 16'h0000) return {31'b0, m_en};
    if (b == 16'h0004) return {spike_count_i, 15'b0, busy_i};
    if (b == 16'h0008) return {16'b0, m_thr};
    if (b == 16'h000C) return {24'b0, m_leak};
    if (b == 16'h0010) return m_scratch;
    if (b >= 16'h0100 && b < 16'h0100 + 16'(4*NW)) return {24'b0, m_w[(b - 16'h0100) / 4]};
    return 32'h0;
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [31:0] d);
    logic [15:0] b;
    b = {a[15:2], 2'b00};
    if (b == 16'h0000) begin
      m_en = d[0];
      if (d[1]) m_sc_cyc = cyc;
    end
    else if (b == 16'h0008) m_thr = d[15:0];
    else if (b == 16'h000C) m_leak = d[7:0];
    else if (b == 16'h0010) m_scratch = d;
    else if (b >= 16'h0100 && b < 16'h0100 + 16'(4*NW)) m_w[(b - 16'h0100) / 4] = d[7:0];
  endtask

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      logic [NW*8-1:0] wexp;
      for (int i = 0; i < NW; i++) wexp[8*i +: 8] = m_w[i];
      chk("snn_enable", 128'(en1), 128'(m_en));
      chk("threshold", 128'(thr1), 128'(m_thr));
      chk("leak", 128'(lk1), 128'(m_leak));
      chk("weights", 128'(w1), 128'(wexp));
      chk("soft_clear", 128'(sc1), 128'(cyc == m_sc_cyc));
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 right after the completion edge.
  task automatic xfer(input logic tgt, input logic wr, input logic [15:0] a,
                      input logic [31:0] d, output logic [31:0] rd, output int acc);
    logic done;
    rd = '0; done = 1'b0; acc = 0;
    target = tgt; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    while (!done && acc < 20) begin
      acc++;
      @(negedge clk);
      if (pready_m) begin
        rd = prdata_m;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("xfer_timeout", 128'(0), 128'(1));
    if (done && wr && !tgt) model_write(a, d);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rd_reg(input string name, input logic [15:0] a, input logic [31:0] lit);
    logic [31:0] rd, exp;
    int acc;
    @(posedge clk); #1;
    exp = m_read(a);
    xfer(1'b0, 1'b0, a, 32'h0, rd, acc);
    chk(name, 128'(rd), 128'(exp));
    chk({name, "_lit"}, 128'(rd), 128'(lit));
    chk("rd_latency", 128'(acc), 128'(2));
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [31:0] d);
    logic [31:0] rd;
    int acc;
    @(posedge clk); #1;
    xfer(1'b0, 1'b1, a, d, rd, acc);
    chk("wr_latency", 128'(acc), 128'(2));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    int acc, t0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    @(negedge clk);
    chk("rst_pready", 128'(b1.pready), 128'(0));
    chk("rst_prdata", 128'(b1.prdata), 128'(0));
    chk("rst_state", 128'(st1), 128'(0));
    chk("rst_threshold_lit", 128'(thr1), 128'(16'h0100));

    rd_reg("rd_ctrl", 16'h0000, 32'h0);
    rd_reg("rd_thr", 16'h0008, 32'h0000_0100);
    rd_reg("rd_leak", 16'h000C, 32'h0000_0001);
    rd_reg("rd_scratch", 16'h0010, 32'h0);
    rd_reg("rd_w0", 16'h0100, 32'h0);
    busy_i = 1'b1; spike_count_i = 16'hBEEF;
    rd_reg("rd_status", 16'h0004, 32'hBEEF_0001);
    busy_i = 1'b0; spike_count_i = 16'h0000;

    wr_reg(16'h0010, 32'hA5A5_5A5A);
    rd_reg("rd_scratch_w", 16'h0010, 32'hA5A5_5A5A);
    wr_reg(16'h0008, 32'hFFFF_1234);
    rd_reg("rd_thr_w", 16'h0008, 32'h0000_1234);
    chk("thr_out_lit", 128'(thr1), 128'(16'h1234));

    wr_reg(16'h013C, 32'h0000_0081);
    chk("w15_lit", 128'(w1[127:120]), 128'(8'h81));
    rd_reg("rd_w15", 16'h013C, 32'h0000_0081);
    wr_reg(16'h0140, 32'h0000_0055);
    rd_reg("rd_unmapped", 16'h0140, 32'h0);
    rd_reg("rd_addr_lsb_ignored", 16'h000F, 32'h0000_0001);

    wr_reg(16'h0000, 32'h0000_0003);
    @(negedge clk);
    chk("soft_clear_hi", 128'(sc1), 128'(1));
    chk("enable_lit", 128'(en1), 128'(1));
    @(negedge clk);
    chk("soft_clear_lo", 128'(sc1), 128'(0));
    rd_reg("rd_ctrl_w", 16'h0000, 32'h0000_0001);

    // Abort: psel dropped while the write sits in its wait state
    @(posedge clk); #1;
    target = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h000C; pwdata = 32'h7F;
    @(posedge clk); #1;
    psel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_pready", 128'(b1.pready), 128'(0));
    end
    chk("abort_leak_lit", 128'(lk1), 128'(8'h01));
    rd_reg("rd_leak_after_abort", 16'h000C, 32'h0000_0001);

    // Reset asserted while a SCRATCH write is in its ACK cycle
    @(posedge clk); #1;
    target = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0010; pwdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_pready", 128'(b1.pready), 128'(1));
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_async_pready", 128'(b1.pready), 128'(0));
    chk("rst_async_state", 128'(st1), 128'(0));
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #3 rst = 1'b0;
    rd_reg("rd_scratch_after_rst", 16'h0010, 32'h0);
    rd_reg("rd_ctrl_after_rst", 16'h0000, 32'h0);

    // Zero-wait instance: back-to-back writes, two cycles each, no idle between
    @(posedge clk); #1;
    t0 = cyc;
    xfer(1'b1, 1'b1, 16'h0010, 32'h1122_3344, rd, acc);
    chk("b2b_acc0", 128'(acc), 128'(1));
    xfer(1'b1, 1'b1, 16'h0008, 32'h0000_5678, rd, acc);
    chk("b2b_acc1", 128'(acc), 128'(1));
    xfer(1'b1, 1'b1, 16'h0100, 32'h0000_0012, rd, acc);
    chk("b2b_acc2", 128'(acc), 128'(1));
    chk("b2b_cycles", 128'(cyc - t0), 128'(6));
    xfer(1'b1, 1'b0, 16'h0010, 32'h0, rd, acc);
    chk("w0_rd_scratch", 128'(rd), 128'(32'h1122_3344));
    chk("w0_rd_acc", 128'(acc), 128'(1));
    xfer(1'b1, 1'b0, 16'h0008, 32'h0, rd, acc);
    chk("w0_rd_thr", 128'(rd), 128'(32'h0000_5678));
    xfer(1'b1, 1'b0, 16'h0100, 32'h0, rd, acc);
    chk("w0_rd_w0", 128'(rd), 128'(32'h0000_0012));
    chk("w0_thr_out", 128'(thr0), 128'(16'h5678));
    chk("w0_weight0_out", 128'(w0[7:0]), 128'(8'h12));
    target = 1'b0;

    repeat (3) @(posedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
